// File: rtl/sram_like_slave_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_slave_pkg
// Shared definitions for the SRAM-like responder: reset polarity, bus size
// encodings, the response-queue entry layout and the byte-lane helpers.
//
// Contents:
//   RST_ENABLE   level of resetn that means "in reset" (active-high)
//   size_e       SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD
//   resp_t       one queued response {isRead, err, data}
//   byteEnable   lane mask for a store, from size and addr[1:0]
//   isBadAccess  reserved size or misaligned address
// -----------------------------------------------------------------------------
package sram_like_slave_pkg;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef struct packed {
        logic        isRead;
        logic        err;
        logic [31:0] data;
    } resp_t;

    // Halfwords only look at addr[1], so a misaligned halfword lands on its
    // aligned pair; words and the reserved size write every lane.
    function automatic logic [3:0] byteEnable(input logic [1:0] size,
                                              input logic [1:0] addrLow);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addrLow;
            SIZE_HALF: be = addrLow[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic isBadAccess(input logic [1:0] size,
                                         input logic [1:0] addrLow);
        return (size == SIZE_RSVD)
            || ((size == SIZE_HALF) && addrLow[0])
            || ((size == SIZE_WORD) && (addrLow != 2'b00));
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// -----------------------------------------------------------------------------
// sram_like_resp_fifo
// In-order queue of pending responses. Every entry carries a down-counter
// loaded with RESP_DELAY-1 on push; the head entry is handed out (and popped)
// in the first cycle its counter reads zero. Because at most one entry is
// pushed per cycle and the head always pops when ready, later entries never
// become ready before earlier ones have been retired.
//
// Parameters: DEPTH (power of 2, >= 2), RESP_DELAY (1..15)
// Ports:
//   clk          in   clock
//   i_reset      in   synchronous reset, drops all entries
//   i_push       in   enqueue i_pushData (ignored when full)
//   i_pushData   in   response entry
//   o_full       out  DEPTH entries held
//   o_empty      out  no entries held
//   o_headReady  out  head entry is due this cycle (it pops at the edge)
//   o_headData   out  head entry contents
// -----------------------------------------------------------------------------
module sram_like_resp_fifo
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESP_DELAY = 2
) (
    input  logic  clk,
    input  logic  i_reset,
    input  logic  i_push,
    input  resp_t i_pushData,
    output logic  o_full,
    output logic  o_empty,
    output logic  o_headReady,
    output resp_t o_headData
);

    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);
    localparam logic [3:0]  CNT_LOAD   = 4'(RESP_DELAY - 1);

    resp_t         r_entry [DEPTH];
    logic [3:0]    r_cnt   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full      = (r_count == FULL_LEVEL);
    assign o_empty     = (r_count == '0);
    assign o_headReady = !o_empty && (r_cnt[r_head] == 4'd0);
    assign o_headData  = r_entry[r_head];

    assign w_push = i_push && !o_full;
    assign w_pop  = o_headReady;

    // Pointers wrap naturally since DEPTH is a power of two; a push and a pop
    // in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload and delay counters need no reset: occupancy alone decides what
    // is live. Counters tick down every cycle and rest at zero; the slot being
    // pushed takes the fresh load instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt[i] != 4'd0) begin
                r_cnt[i] <= r_cnt[i] - 4'd1;
            end
        end
        if (w_push) begin
            r_entry[r_tail] <= i_pushData;
            r_cnt[r_tail]   <= CNT_LOAD;
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// -----------------------------------------------------------------------------
// sram_like_slave
// Responder end of the SRAM-like bus backed by a word-addressed memory of
// 2**MEM_AW 32-bit words. Accepts up to DEPTH outstanding requests and answers
// them in acceptance order RESP_DELAY cycles after each address handshake.
//
// Optional feature macro: SRAM_SLAVE_ERR_EN
//   defined   -> extra output err; reserved size or misaligned accesses are
//                flagged with the response, do not write, and read back 0
//   undefined -> size 3 behaves as a word, misaligned low bits are ignored
//
// Parameters: MEM_AW (10), DEPTH (4), RESP_DELAY (2)
// Ports:
//   clk      in   clock
//   resetn   in   synchronous reset, asserted when resetn == RST_ENABLE (1)
//   req      in   request valid
//   wr       in   1 = write, 0 = read
//   size     in   0 byte, 1 half, 2 word
//   addr     in   byte address; bits above MEM_AW+1 alias
//   wdata    in   lane-aligned write data
//   addr_ok  out  can accept this cycle (handshake = req & addr_ok)
//   data_ok  out  one-cycle response pulse, in acceptance order
//   rdata    out  read word with a read response, otherwise 0
//   err      out  (SRAM_SLAVE_ERR_EN only) bad-access flag with data_ok
// -----------------------------------------------------------------------------
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter int DEPTH      = 4,
    parameter int RESP_DELAY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
`ifdef SRAM_SLAVE_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int MEM_WORDS = 1 << MEM_AW;

    logic [31:0] r_mem [MEM_WORDS];

    logic              w_reset;
    logic              w_full;
    logic              w_empty;
    logic              w_headReady;
    logic              w_accept;
    logic              w_bad;
    logic [3:0]        w_be;
    logic [MEM_AW-1:0] w_index;
    resp_t             w_pushData;
    resp_t             w_headData;
    logic              w_unusedBits;

    assign w_reset = (resetn == RST_ENABLE);
    assign w_index = addr[MEM_AW+1:2];
    assign w_be    = byteEnable(size, addr[1:0]);

`ifdef SRAM_SLAVE_ERR_EN
    assign w_bad = isBadAccess(size, addr[1:0]);
`else
    assign w_bad = 1'b0;
`endif

    // Held low through reset so a master never sees a handshake while the
    // queue is being flushed; otherwise purely a function of queue occupancy.
    assign addr_ok  = !w_reset && !w_full;
    assign w_accept = req && addr_ok;

    // The read word is sampled before this cycle's write lands, so a read sees
    // every earlier write but not one accepted in the same cycle.
    always_comb begin
        w_pushData        = '0;
        w_pushData.isRead = !wr;
        w_pushData.err    = w_bad;
        if (!wr && !w_bad) begin
            w_pushData.data = r_mem[w_index];
        end
    end

    // Byte-lane write at the handshake edge; memory survives reset so a
    // simulation can keep its preloaded image across a reset.
    always_ff @(posedge clk) begin
        if (w_accept && wr && !w_bad) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_index][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    sram_like_resp_fifo #(
        .DEPTH      (DEPTH),
        .RESP_DELAY (RESP_DELAY)
    ) u_respFifo (
        .clk         (clk),
        .i_reset     (w_reset),
        .i_push      (w_accept),
        .i_pushData  (w_pushData),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_headReady (w_headReady),
        .o_headData  (w_headData)
    );

    // Response outputs come straight from the registered head entry; reset
    // masks them so a flushed request can never surface.
    assign data_ok = !w_reset && !w_empty && w_headReady;
    assign rdata   = (data_ok && w_headData.isRead) ? w_headData.data : 32'h0;

`ifdef SRAM_SLAVE_ERR_EN
    assign err          = data_ok && w_headData.err;
    assign w_unusedBits = ^{addr[31:MEM_AW+2]};
`else
    assign w_unusedBits = ^{addr[31:MEM_AW+2], w_headData.err};
`endif

endmodule

// File: tb/tb_sram_like_slave.sv
// -----------------------------------------------------------------------------
// tb_sram_like_slave
// Directed bench for sram_like_slave. Two instances share clock and reset:
// "dut" with the default RESP_DELAY of 2 and "slow" with RESP_DELAY of 6 to
// exercise the full/backpressure path. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_sram_like_slave;
    import sram_like_slave_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;

    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        slowReq, slowWr;
    logic [1:0]  slowSize;
    logic [31:0] slowAddr, slowWdata;
    logic        slowAddrOk, slowDataOk;
    logic [31:0] slowRdata;

`ifdef SRAM_SLAVE_ERR_EN
    logic        err, slowErr;
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Burst table for the default-delay instance
    logic        bWr       [16];
    logic [1:0]  bSize     [16];
    logic [31:0] bAddr     [16];
    logic [31:0] bWdata    [16];
    logic [31:0] bExpRdata [16];
    logic        bExpErr   [16];
    int          bLen = 0;

    // Hand-derived schedule for continuous reads with RESP_DELAY 6, DEPTH 4
    logic [13:0] t5AddrOk = 14'b00011110001111;
    logic [17:0] t5DataOk = 18'b011110001111000000;
    int          t5Idx [14] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7, 8, 8, 8};
    logic [31:0] slowVal [4] = '{32'h60606060, 32'h61616161, 32'h62626262, 32'h63636363};

    always #5 clk = ~clk;

    sram_like_slave dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
`ifdef SRAM_SLAVE_ERR_EN
        ,
        .err     (err)
`endif
    );

    sram_like_slave #(.MEM_AW(10), .DEPTH(4), .RESP_DELAY(6)) slow (
        .clk     (clk),
        .resetn  (resetn),
        .req     (slowReq),
        .wr      (slowWr),
        .size    (slowSize),
        .addr    (slowAddr),
        .wdata   (slowWdata),
        .addr_ok (slowAddrOk),
        .data_ok (slowDataOk),
        .rdata   (slowRdata)
`ifdef SRAM_SLAVE_ERR_EN
        ,
        .err     (slowErr)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit toSlow, input logic r, input logic w,
                                 input logic [1:0] s, input logic [31:0] a,
                                 input logic [31:0] d);
        if (toSlow) begin
            slowReq = r; slowWr = w; slowSize = s; slowAddr = a; slowWdata = d;
        end else begin
            req = r; wr = w; size = s; addr = a; wdata = d;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic addVec(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] expR, input logic expE);
        bWr[bLen] = w; bSize[bLen] = s; bAddr[bLen] = a; bWdata[bLen] = d;
        bExpRdata[bLen] = expR; bExpErr[bLen] = expE;
        bLen++;
    endtask

    // Issues the table back to back; responses must follow two cycles later,
    // one per cycle, with addr_ok staying high throughout.
    task automatic runBurst(input string tag);
        for (int c = 0; c < bLen + 3; c++) begin
            step();
            if (c < bLen) begin
                applyStimulus(1'b0, 1'b1, bWr[c], bSize[c], bAddr[c], bWdata[c]);
                checkOutput($sformatf("%s_addr_ok_c%0d", tag, c), 32'(addr_ok), 32'd1);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
            end
            if (c < 2 || c >= bLen + 2) begin
                checkOutput($sformatf("%s_data_ok_c%0d", tag, c), 32'(data_ok), 32'd0);
                checkOutput($sformatf("%s_rdata_idle_c%0d", tag, c), rdata, 32'h0);
            end else begin
                checkOutput($sformatf("%s_data_ok_c%0d", tag, c), 32'(data_ok), 32'd1);
                checkOutput($sformatf("%s_rdata_c%0d", tag, c), rdata, bExpRdata[c-2]);
`ifdef SRAM_SLAVE_ERR_EN
                checkOutput($sformatf("%s_err_c%0d", tag, c), 32'(err), 32'(bExpErr[c-2]));
`endif
            end
        end
        bLen = 0;
    endtask

    initial begin
        resetn = 1'b1;
        req = 1'b0; wr = 1'b0; size = SIZE_WORD; addr = 32'h0; wdata = 32'h0;
        slowReq = 1'b0; slowWr = 1'b0; slowSize = SIZE_WORD; slowAddr = 32'h0; slowWdata = 32'h0;

        // Reset held three cycles with req asserted: bus stays quiet
        for (int i = 0; i < 3; i++) begin
            step();
            applyStimulus(1'b0, 1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0);
            checkOutput($sformatf("rst_addr_ok_%0d", i), 32'(addr_ok), 32'd0);
            checkOutput($sformatf("rst_data_ok_%0d", i), 32'(data_ok), 32'd0);
            checkOutput($sformatf("rst_rdata_%0d", i), rdata, 32'h0);
        end
        step();
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        checkOutput("post_rst_addr_ok", 32'(addr_ok), 32'd1);
        checkOutput("post_rst_slow_addr_ok", 32'(slowAddrOk), 32'd1);
        checkOutput("post_rst_data_ok", 32'(data_ok), 32'd0);

        // Word write then immediate read of the same address
        addVec(1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        addVec(1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        runBurst("wr_rd");

        // Byte and halfword lane merging, plus address aliasing
        addVec(1'b1, SIZE_WORD, 32'h200, 32'h11223344, 32'h0, 1'b0);
        addVec(1'b1, SIZE_BYTE, 32'h202, 32'h00AB0000, 32'h0, 1'b0);
        addVec(1'b1, SIZE_WORD, 32'h204, 32'h55667788, 32'h0, 1'b0);
        addVec(1'b1, SIZE_HALF, 32'h206, 32'hBEEF0000, 32'h0, 1'b0);
        addVec(1'b1, SIZE_BYTE, 32'h207, 32'h99000000, 32'h0, 1'b0);
        addVec(1'b0, SIZE_WORD, 32'h200, 32'h0, 32'h11AB3344, 1'b0);
        addVec(1'b0, SIZE_WORD, 32'h204, 32'h0, 32'h99EF7788, 1'b0);
        addVec(1'b0, SIZE_WORD, 32'h10000200, 32'h0, 32'h11AB3344, 1'b0);
        runBurst("lanes");

        // Held req: 8 writes then 8 reads, every cycle accepted, responses in order
        for (int i = 0; i < 8; i++) begin
            addVec(1'b1, SIZE_WORD, 32'h300 + 32'(4*i), 32'hA5000000 | 32'(i), 32'h0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            addVec(1'b0, SIZE_WORD, 32'h300 + 32'(4*i), 32'h0, 32'hA5000000 | 32'(i), 1'b0);
        end
        runBurst("stream");

        // Reserved size and misaligned accesses
        addVec(1'b1, SIZE_WORD, 32'h101, 32'h12345678, 32'h0, ERR_EN);
        addVec(1'b0, SIZE_WORD, 32'h100, 32'h0, ERR_EN ? 32'hDEADBEEF : 32'h12345678, 1'b0);
        addVec(1'b1, SIZE_WORD, 32'h108, 32'h77777777, 32'h0, 1'b0);
        addVec(1'b1, SIZE_RSVD, 32'h108, 32'h0BADF00D, 32'h0, ERR_EN);
        addVec(1'b0, SIZE_WORD, 32'h108, 32'h0, ERR_EN ? 32'h77777777 : 32'h0BADF00D, 1'b0);
        addVec(1'b0, SIZE_WORD, 32'h101, 32'h0, ERR_EN ? 32'h0 : 32'h12345678, ERR_EN);
        runBurst("bad_access");

        // Slow instance: preload four words, let them drain
        for (int k = 0; k < 4; k++) begin
            step();
            applyStimulus(1'b1, 1'b1, 1'b1, SIZE_WORD, 32'h40 + 32'(4*k), slowVal[k]);
            checkOutput($sformatf("slow_pre_addr_ok_%0d", k), 32'(slowAddrOk), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            applyStimulus(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        end
        checkOutput("slow_pre_drained", 32'(slowDataOk), 32'd0);

        // Continuous reads against a 4-deep queue with a 6-cycle delay
        begin
            int k = 0;
            for (int c = 0; c < 18; c++) begin
                step();
                if (c < 14) begin
                    applyStimulus(1'b1, 1'b1, 1'b0, SIZE_WORD, 32'h40 + 32'(4*(t5Idx[c] % 4)), 32'h0);
                    checkOutput($sformatf("full_addr_ok_c%0d", c), 32'(slowAddrOk), 32'(t5AddrOk[c]));
                end else begin
                    applyStimulus(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
                end
                checkOutput($sformatf("full_data_ok_c%0d", c), 32'(slowDataOk), 32'(t5DataOk[c]));
                if (t5DataOk[c]) begin
                    checkOutput($sformatf("full_rdata_k%0d", k), slowRdata, slowVal[k % 4]);
                    k++;
                end else begin
                    checkOutput($sformatf("full_rdata_idle_c%0d", c), slowRdata, 32'h0);
                end
            end
        end

        // Reset with three reads outstanding: responses must vanish
        for (int c = 0; c < 3; c++) begin
            step();
            applyStimulus(1'b1, 1'b1, 1'b0, SIZE_WORD, 32'h40 + 32'(4*c), 32'h0);
            checkOutput($sformatf("flush_addr_ok_%0d", c), 32'(slowAddrOk), 32'd1);
        end
        for (int c = 3; c < 15; c++) begin
            step();
            if (c == 3) begin
                resetn = 1'b1;
            end else if (c == 5) begin
                resetn = 1'b0;
            end
            applyStimulus(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
            checkOutput($sformatf("flush_slow_data_ok_c%0d", c), 32'(slowDataOk), 32'd0);
            checkOutput($sformatf("flush_data_ok_c%0d", c), 32'(data_ok), 32'd0);
            if (c < 5) begin
                checkOutput($sformatf("flush_addr_ok_rst_c%0d", c), 32'(slowAddrOk), 32'd0);
            end
        end

        // Memory survives reset in both instances
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, SIZE_WORD, 32'h44, 32'h0);
        checkOutput("keep_slow_addr_ok", 32'(slowAddrOk), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            step();
            applyStimulus(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
            if (i < 6) begin
                checkOutput($sformatf("keep_slow_wait_%0d", i), 32'(slowDataOk), 32'd0);
            end else begin
                checkOutput("keep_slow_data_ok", 32'(slowDataOk), 32'd1);
                checkOutput("keep_slow_rdata", slowRdata, 32'h61616161);
`ifdef SRAM_SLAVE_ERR_EN
                checkOutput("keep_slow_err", 32'(slowErr), 32'd0);
`endif
            end
        end
        addVec(1'b0, SIZE_WORD, 32'h100, 32'h0, ERR_EN ? 32'hDEADBEEF : 32'h12345678, 1'b0);
        runBurst("keep");

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
